send_row: RTL and testbench
===========================

# send_row

Row serializer between the host-side loader (`cpu`) and the CNN accelerator input port. While an image load is in progress, each `send` edge captures one 480-bit image row and streams it out as 30 consecutive 16-bit words, one per clock, then pulses a row-complete flag. A `stop` level aborts or blocks transfers.

## Interface
Parameters:
- ROW_W, 480, width of one image row.
- WORD_W, 16, width of one output word; ROW_W must be an integer multiple of WORD_W.
- WORDS, ROW_W/WORD_W (30), derived word count per row; not overridable.

Ports (declaration order: row, clk, load_process, send, stop, rst, data_out, data_valid, busy, row_done, rows_sent):
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  one clock; reset is asynchronous and active-low (rst=0 resets).
- row  input  ROW_W  row to transmit; stable from before the detected `send` edge until capture.
- load_process  input  1  level; high while an image load is active.
- send  input  1  request; a rising edge requests transmission of `row`. May be asynchronous to clk.
- stop  input  1  level; high blocks new rows and aborts a row in flight.
- data_out  output  WORD_W  current word.
- data_valid  output  1  data_out valid this cycle.
- busy  output  1  row capture/stream in progress.
- row_done  output  1  one-cycle pulse after the last word of a row.
- rows_sent  output  10  completed rows since load_process last rose; saturates at 1023.

## Operation
- `send` passes through a 2-flop synchronizer plus a third flop; `send_edge = s2 & ~s3`.
- States: IDLE, STREAM.
- IDLE: if `send_edge & load_process & ~stop`: capture `row` into a ROW_W shift register, clear the word counter, go to STREAM. Otherwise stay; a qualifying edge missed here is dropped, not queued.
- STREAM: each cycle drive `data_out = shreg[WORD_W-1:0]` (word 0 = row[15:0], word 29 = row[479:464]) with `data_valid=1`, shift right by WORD_W, increment the counter. After word WORDS-1 return to IDLE and assert `row_done` next cycle; `rows_sent` increments with row_done (saturating).
- `send_edge` during STREAM is ignored.
- `stop=1` or `load_process=0` during STREAM: abort at the next clock edge. Return to IDLE with `data_valid=0`, no `row_done`, and rows_sent unchanged.
- Rising edge of `load_process` (registered detection) clears rows_sent to 0.
- data_out is 0 whenever data_valid=0.

## Timing
- Reset: all outputs 0, state IDLE, synchronizer flops 0, shift register 0.
- `send` rising before clk edge N (setup met) -> s1 at N, s2 at N+1, edge detected and row captured at N+2. First data_valid in cycle N+2..N+3, i.e. word 0 is visible after edge N+2.
- 30 valid cycles back-to-back with no gaps; busy is high in those same 30 cycles.
- row_done is high for exactly the cycle after the last valid word. busy=0 in that cycle, and a new capture may occur in it.
- Minimum row period: 3 + 30 cycles from send edge to the next acceptable capture.
- Asynchronous reset mid-stream clears immediately with no row_done.

## Test plan
- Reset: hold rst=0 with `send` toggling -> all outputs 0. Release -> still idle until the first qualifying send edge.
- Single row: row = words 0..29 with values 16'h0000..16'h001D, load_process=1, pulse send -> 30 valid words 0x0000..0x001D in order, then row_done pulse, rows_sent=1.
- Back-to-back: 3 rows with send pulses spaced 40 cycles apart -> 90 words, 3 row_done pulses, rows_sent=3. A send pulse issued at word 10 of row 2 is ignored (still 3 rows).
- Stop: assert stop at word 12 -> data_valid drops at the next edge, no row_done, rows_sent unchanged. A send pulse with stop=1 -> no transfer.
- load_process gating: send pulse with load_process=0 -> no transfer. load_process 0->1 after rows_sent=3 -> rows_sent=0.
- Reset mid-stream: rst=0 at word 5 -> outputs 0 immediately. After release, a new send gives a full 30-word row.

Source files
------------

// File: rtl/send_row.sv
// Row serializer: captures one ROW_W image row per synchronized send edge and streams it as WORD_W words.
// Latency: word 0 appears 3 clocks after send rises; WORDS valid words back-to-back, row_done the cycle after.
// Backpressure: none downstream; stop or a dropped load_process aborts a row, sends seen while busy are dropped.
module send_row #(
    parameter int ROW_W  = 480,
    parameter int WORD_W = 16
) (
    input  logic [ROW_W-1:0]  row,
    input  logic              clk,
    input  logic              load_process,
    input  logic              send,
    input  logic              stop,
    input  logic              rst,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              row_done,
    output logic [9:0]        rows_sent
);

    // Word count is derived from the row geometry and is not a free parameter.
    localparam int WORDS = ROW_W / WORD_W;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // send may come from another clock domain: two flops to settle, a third for edge detect.
    logic              send_s1;
    logic              send_s2;
    logic              send_s3;
    logic              send_edge;

    logic              load_q;
    logic              load_rise;

    logic [ROW_W-1:0]  shreg;
    logic [CNT_W-1:0]  word_cnt;

    logic              start;
    logic              abort;
    logic              last;
    logic              complete;

    assign send_edge = send_s2 & ~send_s3;
    assign load_rise = load_process & ~load_q;

    // A capture needs an active load and no stop; either condition going away kills a row in flight.
    assign start     = send_edge & load_process & ~stop;
    assign abort     = stop | ~load_process;
    assign last      = (word_cnt == LAST_WORD);
    assign complete  = (state == STREAM) & ~abort & last;

    // Synchronizer chain for the asynchronous send request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            send_s1 <= 1'b0;
            send_s2 <= 1'b0;
            send_s3 <= 1'b0;
        end else begin
            send_s1 <= send;
            send_s2 <= send_s1;
            send_s3 <= send_s2;
        end
    end

    // Registered copy of load_process so a new image load can be detected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q <= 1'b0;
        end else begin
            load_q <= load_process;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: abort has priority over completing the final word.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (abort || last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: the low word of the shift register is the word on the bus, zeroed when not valid.
    always_comb begin
        data_valid = 1'b0;
        busy       = 1'b0;
        data_out   = '0;
        if (state == STREAM) begin
            data_valid = 1'b1;
            busy       = 1'b1;
            data_out   = shreg[WORD_W-1:0];
        end
    end

    // Row shift register and word counter: load on capture, shift one word per streamed cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            word_cnt <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                shreg    <= row;
                word_cnt <= '0;
            end
        end else if (!abort) begin
            shreg    <= shreg >> WORD_W;
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    // Row-complete pulse follows the last word by one cycle; aborted rows never produce it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_done <= 1'b0;
        end else begin
            row_done <= complete;
        end
    end

    // Completed-row count: cleared when a new load starts, saturating otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_sent <= '0;
        end else if (load_rise) begin
            rows_sent <= '0;
        end else if (complete && (rows_sent != 10'h3FF)) begin
            rows_sent <= rows_sent + 10'd1;
        end
    end

endmodule

// File: tb/tb_send_row.sv
// Directed bench for send_row: table of row transfers plus hand sequences for abort, reset and ignored sends.
// Expected words are base+index per row, built by the bench.
// Outputs are sampled 1ns after each rising clock edge.
module tb_send_row;

    logic [479:0] row;
    logic         clk;
    logic         load_process;
    logic         send;
    logic         stop;
    logic         rst;
    logic [15:0]  data_out;
    logic         data_valid;
    logic         busy;
    logic         row_done;
    logic [9:0]   rows_sent;

    int checks   = 0;
    int failures = 0;

    send_row dut (
        .row          (row),
        .clk          (clk),
        .load_process (load_process),
        .send         (send),
        .stop         (stop),
        .rst          (rst),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .busy         (busy),
        .row_done     (row_done),
        .rows_sent    (rows_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] base;
        logic        lp;
        logic        stp;
        logic        xfer;
        logic [9:0]  rows;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [479:0] make_row(input logic [15:0] base);
        logic [479:0] r;
        r = '0;
        for (int i = 0; i < 30; i++) begin
            r[i*16 +: 16] = base + 16'(i);
        end
        return r;
    endfunction

    // Raise send for two cycles; word 0 must appear exactly three edges after the rise.
    task automatic do_send();
        send = 1'b1;
        tick();
        tick();
        chk("pre_valid", 32'(data_valid), 32'd0);
        send = 1'b0;
        tick();
    endtask

    // Check all 30 words in order, then the row_done pulse.
    task automatic stream_full(input logic [15:0] base);
        for (int i = 0; i < 30; i++) begin
            chk("word_valid", 32'(data_valid), 32'd1);
            chk("word_data", 32'(data_out), 32'(base + 16'(i)));
            chk("word_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("done_pulse", 32'(row_done), 32'd1);
        chk("done_valid", 32'(data_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_data", 32'(data_out), 32'd0);
        tick();
        chk("done_clear", 32'(row_done), 32'd0);
    endtask

    initial begin
        logic seen;

        vecs[0] = '{16'h0000, 1'b1, 1'b0, 1'b1, 10'd1};
        vecs[1] = '{16'h0100, 1'b1, 1'b0, 1'b1, 10'd2};
        vecs[2] = '{16'h0200, 1'b1, 1'b0, 1'b1, 10'd3};
        vecs[3] = '{16'h0300, 1'b1, 1'b1, 1'b0, 10'd3};
        vecs[4] = '{16'h0400, 1'b0, 1'b0, 1'b0, 10'd3};
        vecs[5] = '{16'h0500, 1'b1, 1'b0, 1'b1, 10'd1};

        rst          = 1'b0;
        send         = 1'b0;
        stop         = 1'b0;
        load_process = 1'b1;
        row          = make_row(16'h0000);

        // Reset held while send toggles: outputs stay zero.
        for (int i = 0; i < 6; i++) begin
            send = ~send;
            tick();
            chk("rst_valid", 32'(data_valid), 32'd0);
            chk("rst_data", 32'(data_out), 32'd0);
        end
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(row_done), 32'd0);
        chk("rst_rows", 32'(rows_sent), 32'd0);
        send = 1'b0;
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (data_valid || busy) seen = 1'b1;
        end
        chk("idle_after_rst", 32'(seen), 32'd0);

        // Table of row transfers.
        for (int v = 0; v < 6; v++) begin
            load_process = vecs[v].lp;
            stop         = vecs[v].stp;
            row          = make_row(vecs[v].base);
            tick();
            tick();
            do_send();
            if (vecs[v].xfer) begin
                stream_full(vecs[v].base);
            end else begin
                seen = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    if (data_valid || busy || row_done) seen = 1'b1;
                    tick();
                end
                chk("no_xfer", 32'(seen), 32'd0);
            end
            chk("tbl_rows", 32'(rows_sent), 32'(vecs[v].rows));
            tick();
        end

        // A new image load clears the count.
        load_process = 1'b0;
        tick();
        chk("rows_hold_lp0", 32'(rows_sent), 32'd1);
        load_process = 1'b1;
        tick();
        chk("rows_clear", 32'(rows_sent), 32'd0);

        // Send pulse during streaming is ignored.
        row = make_row(16'h0600);
        tick();
        do_send();
        for (int i = 0; i < 30; i++) begin
            chk("ign_word", 32'(data_out), 32'(16'h0600 + 16'(i)));
            if (i == 10) send = 1'b1;
            if (i == 12) send = 1'b0;
            tick();
        end
        chk("ign_done", 32'(row_done), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (data_valid || busy) seen = 1'b1;
        end
        chk("ign_no_second", 32'(seen), 32'd0);
        chk("ign_rows", 32'(rows_sent), 32'd1);

        // Stop at word 12 aborts the row.
        row = make_row(16'h0700);
        do_send();
        for (int i = 0; i <= 12; i++) begin
            chk("stop_word", 32'(data_out), 32'(16'h0700 + 16'(i)));
            if (i < 12) tick();
        end
        stop = 1'b1;
        tick();
        chk("stop_valid", 32'(data_valid), 32'd0);
        chk("stop_data", 32'(data_out), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (row_done) seen = 1'b1;
            tick();
        end
        chk("stop_no_done", 32'(seen), 32'd0);
        chk("stop_rows", 32'(rows_sent), 32'd1);
        stop = 1'b0;
        tick();

        // Asynchronous reset at word 5 clears everything at once.
        row = make_row(16'h0800);
        do_send();
        for (int i = 0; i <= 5; i++) begin
            chk("mid_word", 32'(data_out), 32'(16'h0800 + 16'(i)));
            if (i < 5) tick();
        end
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(row_done), 32'd0);
        chk("mid_rst_rows", 32'(rows_sent), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        row = make_row(16'h0900);
        tick();
        do_send();
        stream_full(16'h0900);
        chk("post_rst_rows", 32'(rows_sent), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
